// File: rtl/nreg_arbiter_pkg.sv
// Shared definitions for the N-bit register write-ownership arbiter.
package nreg_arbiter_pkg;

    localparam int unsigned DEF_N     = 8;
    localparam int unsigned DEF_R     = 4;
    localparam int unsigned DEF_BURST = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    // Ceiling log2; callers always pass v >= 2, so the result is at least 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nreg_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after i_ptr, wrapping modulo R.
module nreg_arbiter_rr_pick
    import nreg_arbiter_pkg::*;
#(
    parameter int unsigned R  = DEF_R,
    parameter int unsigned PW = clog2(R)
) (
    input  logic [R-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_sel,
    output logic          o_any
);

    logic [PW-1:0] w_idx [R];

    for (genvar g = 0; g < int'(R); g++) begin : g_rot
        assign w_idx[g] = PW'((32'(i_ptr) + 32'(g)) % R);
    end

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        o_sel = '0;
        o_any = 1'b0;
        for (int k = int'(R) - 1; k >= 0; k--) begin
            if (i_req[w_idx[k]]) begin
                o_sel = w_idx[k];
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nreg_arbiter.sv
// Round-robin write-ownership arbiter with bounded bursts, fronting a shared N-bit register.
module nreg_arbiter
    import nreg_arbiter_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned R     = DEF_R,
    parameter int unsigned BURST = DEF_BURST
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] din,
    output logic [R-1:0]   gnt,
    output logic           wr,
    output logic [2:0]     owner,
    output logic [N-1:0]   Q,
    output logic           busy
);

    localparam int unsigned PW = clog2(R);
    localparam int unsigned CW = clog2(BURST + 1);
    localparam int unsigned OW = 3;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_q, w_q_nxt;
    logic [R-1:0]    r_gnt, w_gnt_nxt;
    logic            r_wr, w_wr_nxt;
    logic            r_busy, w_busy_nxt;
    logic [OW-1:0]   r_owner, w_owner_nxt;
    logic [PW-1:0]   r_ptr, w_ptr_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic [PW-1:0]   w_sel;
    logic            w_any;
    logic [PW-1:0]   w_own_idx;
    logic [PW-1:0]   w_ptr_inc;
    logic [PW-1:0]   w_ld_idx;
    logic [N-1:0]    w_ld_data;
    logic [N-1:0]    w_din [R];

    nreg_arbiter_rr_pick #(
        .R  (R),
        .PW (PW)
    ) u_rr_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_sel (w_sel),
        .o_any (w_any)
    );

    for (genvar g = 0; g < int'(R); g++) begin : g_din
        assign w_din[g] = din[g*N +: N];
    end

    assign w_own_idx = PW'(r_owner);
    assign w_ptr_inc = (w_own_idx == PW'(R - 1)) ? '0 : w_own_idx + PW'(1);

    // IDLE loads the freshly arbitrated winner; OWN keeps reloading from the owner.
    assign w_ld_idx  = (r_state == S_IDLE) ? w_sel : w_own_idx;
    assign w_ld_data = w_din[w_ld_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_gnt_nxt   = r_gnt;
        w_wr_nxt    = 1'b0;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_q_nxt     = w_ld_data;
                    w_gnt_nxt   = R'(1) << w_sel;
                    w_owner_nxt = OW'(w_sel);
                    w_cnt_nxt   = CW'(1);
                    w_wr_nxt    = 1'b1;
                    w_state_nxt = S_OWN;
                end
            end
            S_OWN: begin
                if (req[w_own_idx] && (r_cnt < CW'(BURST))) begin
                    w_q_nxt   = w_ld_data;
                    w_cnt_nxt = r_cnt + CW'(1);
                    w_wr_nxt  = 1'b1;
                end else begin
                    // Release always passes through one dead IDLE cycle.
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_OWN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_gnt   <= '0;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_gnt   <= w_gnt_nxt;
            r_wr    <= w_wr_nxt;
            r_busy  <= w_busy_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign wr    = r_wr;
    assign owner = r_owner;
    assign Q     = r_q;
    assign busy  = r_busy;

endmodule
